// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one registered signed multiplier walks a circular delay line
// over NTAPS cycles per sample. Coefficients live in a run-time writable RAM.
module fir_mac_filter #(
  parameter int NTAPS  = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clkfir,
  input  logic                     reset,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  input  logic [DATA_W-1:0]        s_axis_data_tdata,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic [ACC_W-1:0]         m_axis_data_tdata,
  input  logic                     coef_wr_en,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     coef_err
);
  localparam int AW = $clog2(NTAPS);
  localparam int PW = DATA_W + COEF_W;

  typedef enum logic [2:0] {FLUSH, IDLE, MAC, DRAIN, OUT} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] dline [NTAPS];
  logic signed [COEF_W-1:0] coef  [NTAPS];
  logic [AW-1:0]            wr_ptr, cnt, rd_addr;
  logic signed [PW-1:0]     prod;
  logic                     prod_vld;
  logic [ACC_W-1:0]         acc;
  logic                     drain_ph;
  logic                     coef_ok, accept;

  // Step k reads x[n-k]: walk backwards from the newest sample.
  assign rd_addr = wr_ptr - cnt;
  assign coef_ok = (state == IDLE) || (state == FLUSH);
  assign accept  = (state == IDLE) && s_axis_data_tvalid && s_axis_data_tready;

  // Coefficient RAM is deliberately left out of reset.
  always_ff @(posedge clkfir) begin
    if (coef_wr_en && coef_ok)
      coef[coef_addr] <= coef_data;
  end

  always_ff @(posedge clkfir) begin
    if (!reset) begin
      if (state == FLUSH)
        dline[cnt] <= '0;
      else if (accept)
        dline[wr_ptr] <= s_axis_data_tdata;
    end
  end

  always_ff @(posedge clkfir) begin
    if (reset) begin
      state              <= FLUSH;
      cnt                <= '0;
      wr_ptr             <= '0;
      s_axis_data_tready <= 1'b0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      coef_err           <= 1'b0;
      prod               <= '0;
      prod_vld           <= 1'b0;
      acc                <= '0;
      drain_ph           <= 1'b0;
    end else begin
      coef_err <= coef_wr_en && !coef_ok;
      prod_vld <= (state == MAC);
      if (state == MAC)
        prod <= dline[rd_addr] * coef[cnt];
      if (prod_vld)
        acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

      case (state)
        FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NTAPS-1)) begin
            state              <= IDLE;
            s_axis_data_tready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            s_axis_data_tready <= 1'b0;
            state              <= MAC;
            cnt                <= '0;
            acc                <= '0;
          end
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NTAPS-1))
            state <= DRAIN;
        end
        DRAIN: begin
          // First cycle absorbs the last product, second publishes the sum.
          drain_ph <= ~drain_ph;
          if (drain_ph) begin
            m_axis_data_tdata  <= acc;
            m_axis_data_tvalid <= 1'b1;
            state              <= OUT;
          end
        end
        OUT: begin
          if (m_axis_data_tready) begin
            m_axis_data_tvalid <= 1'b0;
            wr_ptr             <= wr_ptr + 1'b1;
            s_axis_data_tready <= 1'b1;
            state              <= IDLE;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_filter.sv
// Scoreboard bench for fir_mac_filter: a convolution model pushes expected sums on
// each accepted sample; each scenario task pops and compares on output handshakes.
module tb_fir_mac_filter;
  localparam int NT = 16;

  logic        clkfir = 1'b0;
  logic        reset  = 1'b1;
  logic        s_axis_data_tvalid = 1'b0;
  logic        s_axis_data_tready;
  logic [15:0] s_axis_data_tdata  = '0;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready = 1'b0;
  logic [39:0] m_axis_data_tdata;
  logic        coef_wr_en = 1'b0;
  logic [3:0]  coef_addr  = '0;
  logic [15:0] coef_data  = '0;
  logic        coef_err;

  fir_mac_filter #(.NTAPS(NT), .DATA_W(16), .COEF_W(16), .ACC_W(40)) dut (
    .clkfir(clkfir), .reset(reset),
    .s_axis_data_tvalid(s_axis_data_tvalid), .s_axis_data_tready(s_axis_data_tready),
    .s_axis_data_tdata(s_axis_data_tdata),
    .m_axis_data_tvalid(m_axis_data_tvalid), .m_axis_data_tready(m_axis_data_tready),
    .m_axis_data_tdata(m_axis_data_tdata),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err)
  );

  always #5 clkfir = ~clkfir;

  int total = 0;
  int bad   = 0;
  int hm [NT];
  int xs [NT];
  logic [39:0] sb [$];

  task automatic tick();
    @(posedge clkfir);
    #1;
  endtask

  function automatic logic [39:0] model_out();
    longint s;
    s = 0;
    for (int k = 0; k < NT; k++) s += longint'(hm[k]) * longint'(xs[k]);
    return s[39:0];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NT; k++) xs[k] = 0;
    sb.delete();
  endtask

  task automatic load_coef(input int k, input int v);
    coef_wr_en = 1'b1; coef_addr = 4'(k); coef_data = 16'(v);
    tick();
    coef_wr_en = 1'b0;
    hm[k] = v;
  endtask

  task automatic push_sample(input int x, input bit we, input int wa, input int wd);
    int n;
    n = 0;
    while (s_axis_data_tready !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (s_axis_data_tready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout tready=%b required=1", s_axis_data_tready);
      return;
    end
    s_axis_data_tvalid = 1'b1; s_axis_data_tdata = 16'(x);
    coef_wr_en = we; coef_addr = 4'(wa); coef_data = 16'(wd);
    tick();
    s_axis_data_tvalid = 1'b0; coef_wr_en = 1'b0;
    if (we) hm[wa] = wd;
    for (int k = NT-1; k > 0; k--) xs[k] = xs[k-1];
    xs[0] = x;
    sb.push_back(model_out());
  endtask

  task automatic wait_out(output bit ok, output int lat);
    lat = 0;
    while (m_axis_data_tvalid !== 1'b1 && lat < 200) begin tick(); lat++; end
    ok = (m_axis_data_tvalid === 1'b1);
  endtask

  task automatic take();
    m_axis_data_tready = 1'b1;
    tick();
    m_axis_data_tready = 1'b0;
  endtask

  function automatic logic [39:0] pop_exp();
    logic [39:0] e;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if (s_axis_data_tready !== 1'b0 || m_axis_data_tvalid !== 1'b0 ||
        m_axis_data_tdata !== 40'h0 || coef_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state tready=%b tvalid=%b tdata=%h coef_err=%b required=0/0/0/0",
               s_axis_data_tready, m_axis_data_tvalid, m_axis_data_tdata, coef_err);
    end
    reset = 1'b0;
    clear_model();
    for (int i = 1; i <= NT; i++) begin
      tick();
      total++;
      if (s_axis_data_tready !== (i == NT) || m_axis_data_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL flush_cycle%0d tready=%b tvalid=%b required=%b/0",
                 i, s_axis_data_tready, m_axis_data_tvalid, i == NT);
      end
    end
  endtask

  task automatic test_impulse();
    bit ok; int lat; logic [39:0] e;
    for (int k = 0; k < NT; k++) load_coef(k, k + 1);
    for (int i = 0; i <= NT; i++) begin
      push_sample(i == 0 ? 1000 : 0, 1'b0, 0, 0);
      wait_out(ok, lat);
      e = pop_exp();
      total++;
      if (!ok || m_axis_data_tdata !== e) begin
        bad++;
        $display("FAIL impulse[%0d] tdata=%h valid=%b required=%h", i, m_axis_data_tdata, ok, e);
      end
      if (i == 0) begin
        total++;
        if (lat != NT + 2) begin
          bad++;
          $display("FAIL impulse_latency got=%0d required=%0d", lat, NT + 2);
        end
      end
      take();
    end
  endtask

  task automatic test_step();
    bit ok; int lat; logic [39:0] e;
    for (int k = 0; k < NT; k++) load_coef(k, 1);
    for (int i = 0; i < 20; i++) begin
      push_sample(100, 1'b0, 0, 0);
      wait_out(ok, lat);
      e = pop_exp();
      total++;
      if (!ok || m_axis_data_tdata !== e) begin
        bad++;
        $display("FAIL step[%0d] tdata=%h valid=%b required=%h", i, m_axis_data_tdata, ok, e);
      end
      take();
    end
  endtask

  task automatic test_extreme();
    bit ok; int lat; logic [39:0] e;
    int xv [2];
    xv[0] = -32768; xv[1] = 32767;
    load_coef(0, -32768);
    for (int k = 1; k < NT; k++) load_coef(k, 0);
    for (int i = 0; i < 2; i++) begin
      push_sample(xv[i], 1'b0, 0, 0);
      wait_out(ok, lat);
      e = pop_exp();
      total++;
      if (!ok || m_axis_data_tdata !== e) begin
        bad++;
        $display("FAIL extreme[%0d] tdata=%h valid=%b required=%h", i, m_axis_data_tdata, ok, e);
      end
      take();
    end
  endtask

  task automatic test_simultaneous();
    bit ok; int lat; logic [39:0] e;
    for (int k = 0; k < NT; k++) load_coef(k, int'($urandom_range(0, 2000)) - 1000);
    for (int i = 0; i < 3; i++) begin
      push_sample(int'($urandom_range(0, 65535)) - 32768, 1'b1, i, -1234 + 1000 * i);
      wait_out(ok, lat);
      e = pop_exp();
      total++;
      if (!ok || m_axis_data_tdata !== e) begin
        bad++;
        $display("FAIL simul_write[%0d] tdata=%h valid=%b required=%h", i, m_axis_data_tdata, ok, e);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [39:0] e; logic [39:0] held;
    push_sample(123, 1'b0, 0, 0);
    wait_out(ok, lat);
    e = pop_exp();
    held = m_axis_data_tdata;
    total++;
    if (!ok || held !== e) begin
      bad++;
      $display("FAIL bp_first tdata=%h valid=%b required=%h", held, ok, e);
    end
    for (int i = 0; i < 5; i++) begin
      s_axis_data_tvalid = 1'b1; s_axis_data_tdata = 16'd777;
      tick();
      total++;
      if (m_axis_data_tdata !== e || m_axis_data_tvalid !== 1'b1 || s_axis_data_tready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] tdata=%h tvalid=%b tready=%b required=%h/1/0",
                 i, m_axis_data_tdata, m_axis_data_tvalid, s_axis_data_tready, e);
      end
    end
    take();
    push_sample(777, 1'b0, 0, 0);
    wait_out(ok, lat);
    e = pop_exp();
    total++;
    if (!ok || m_axis_data_tdata !== e) begin
      bad++;
      $display("FAIL bp_after tdata=%h valid=%b required=%h", m_axis_data_tdata, ok, e);
    end
    take();
  endtask

  task automatic test_dropped_write();
    bit ok; int lat; logic [39:0] e;
    push_sample(500, 1'b0, 0, 0);
    coef_wr_en = 1'b1; coef_addr = 4'd2; coef_data = 16'd9999;
    tick();
    coef_wr_en = 1'b0;
    total++;
    if (coef_err !== 1'b1) begin
      bad++;
      $display("FAIL coef_err_pulse got=%b required=1", coef_err);
    end
    tick();
    total++;
    if (coef_err !== 1'b0) begin
      bad++;
      $display("FAIL coef_err_width got=%b required=0", coef_err);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) push_sample(-700, 1'b0, 0, 0);
      wait_out(ok, lat);
      e = pop_exp();
      total++;
      if (!ok || m_axis_data_tdata !== e) begin
        bad++;
        $display("FAIL dropped_write[%0d] tdata=%h valid=%b required=%h", i, m_axis_data_tdata, ok, e);
      end
      take();
    end
  endtask

  task automatic test_reset_mid_mac();
    bit ok; int lat; logic [39:0] e;
    push_sample(300, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    total++;
    if (m_axis_data_tvalid !== 1'b0 || s_axis_data_tready !== 1'b0) begin
      bad++;
      $display("FAIL midmac_reset tvalid=%b tready=%b required=0/0", m_axis_data_tvalid, s_axis_data_tready);
    end
    for (int k = 0; k < NT; k++) load_coef(k, k + 1);
    for (int i = 0; i < 4; i++) begin
      push_sample(i == 0 ? 1000 : 0, 1'b0, 0, 0);
      wait_out(ok, lat);
      e = pop_exp();
      total++;
      if (!ok || m_axis_data_tdata !== e) begin
        bad++;
        $display("FAIL post_reset_impulse[%0d] tdata=%h valid=%b required=%h", i, m_axis_data_tdata, ok, e);
      end
      take();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NT; k++) hm[k] = 0;
    test_reset();
    test_impulse();
    test_step();
    test_extreme();
    test_simultaneous();
    test_backpressure();
    test_dropped_write();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
